// File: rtl/alu_muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit.
// Shift-add multiply, restoring divide, one bit per cycle.
module alu_muldiv_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'b0101,
  parameter logic [3:0] DIV_CODE = 4'b0110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opnd, work_hi, work_lo;
  logic [WIDTH-1:0] hi_nx, lo_nx, diff;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum, shl;
  logic             go_mul, go_div, go_dz, last, ge;

  // start decode and next-state / handshake outputs
  always_comb begin
    go_mul   = 1'b0;
    go_div   = 1'b0;
    go_dz    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    last     = (count == LAST);
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && alu_control == MUL_CODE) begin
          go_mul   = 1'b1;
          state_nx = MUL;
        end else if (start && alu_control == DIV_CODE) begin
          if (op_b != '0) begin
            go_div   = 1'b1;
            state_nx = DIV;
          end else begin
            go_dz    = 1'b1;
            state_nx = FIN;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // one iteration step of the shared working registers
  always_comb begin
    sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    shl   = {work_hi, work_lo[WIDTH-1]};
    ge    = (shl >= {1'b0, opnd});
    diff  = shl[WIDTH-1:0] - opnd;
    hi_nx = work_hi;
    lo_nx = work_lo;
    if (state == MUL) begin
      {hi_nx, lo_nx} = {sum, work_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      hi_nx = ge ? diff : shl[WIDTH-1:0];
      lo_nx = {work_lo[WIDTH-2:0], ge};
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // operand latch, iteration and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      count     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else if (go_mul) begin
      opnd     <= op_a;
      work_hi  <= '0;
      work_lo  <= op_b;
      count    <= '0;
      div_zero <= 1'b0;
    end else if (go_div) begin
      opnd     <= op_b;
      work_hi  <= '0;
      work_lo  <= op_a;
      count    <= '0;
      div_zero <= 1'b0;
    end else if (go_dz) begin
      result_lo <= '1;
      result_hi <= op_a;
      div_zero  <= 1'b1;
    end else if (busy) begin
      work_hi <= hi_nx;
      work_lo <= lo_nx;
      count   <= count + 1'b1;
      if (last) begin
        result_hi <= hi_nx;
        result_lo <= lo_nx;
      end
    end
  end

endmodule
